// File: rtl/uart_port_ctrl_pkg.sv
// rtl/uart_port_ctrl_pkg.sv - shared types, status bit positions and helpers for the COM1 controller
package uart_port_ctrl_pkg;

    localparam int TX_READY_BIT = 0;
    localparam int RX_READY_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_STROBE = 2'd1,
        ST_WR_STROBE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    function automatic logic [15:0] status_word(input logic rx_ready, input logic tx_rdy);
        logic [15:0] w;
        w = '0;
        w[TX_READY_BIT] = tx_rdy;
        w[RX_READY_BIT] = rx_ready;
        return w;
    endfunction

endpackage

// File: rtl/uart_port_ctrl_if.sv
// rtl/uart_port_ctrl_if.sv - request/response channel between the memory stage and the COM1 controller
interface uart_port_ctrl_if;
    logic        req_read;
    logic        req_write;
    logic        req_cmd;
    logic [7:0]  wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        done;

    modport master (
        output req_read, req_write, req_cmd, wdata,
        input  rdata, busy, done
    );

    modport slave (
        input  req_read, req_write, req_cmd, wdata,
        output rdata, busy, done
    );
endinterface

// File: rtl/uart_port_ctrl_strobe_timer.sv
// rtl/uart_port_ctrl_strobe_timer.sv - loadable down-counter flagging the last cycle of a strobe
module uart_port_ctrl_strobe_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          last
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == '0);

endmodule

// File: rtl/uart_port_ctrl.sv
// rtl/uart_port_ctrl.sv - COM1 access controller: times rdn/wrn strobes and owns the RAM1 low byte
module uart_port_ctrl
    import uart_port_ctrl_pkg::*;
#(
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2
) (
    input  logic             clk,
    input  logic             rst,
    uart_port_ctrl_if.slave  host,
    output logic             tx_ready,
    inout  wire  [7:0]       bus_data,
    output logic             bus_hold,
    output logic             rdn,
    output logic             wrn,
    input  logic             tbre,
    input  logic             tsre,
    input  logic             data_ready
);

    localparam int PMAX = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int CW   = (PMAX < 2) ? 1 : $clog2(PMAX);

    state_t      state_q, state_d;
    logic        rdn_d, wrn_d, hold_d;
    logic        drive_q, drive_d;
    logic [7:0]  wbyte_q, wbyte_d;
    logic [15:0] rdata_q, rdata_d;
    logic        tx_busy;
    logic        set_tx_busy;
    logic        tmr_load, tmr_en, tmr_last;
    logic [CW-1:0] tmr_val;

    uart_port_ctrl_strobe_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .last     (tmr_last)
    );

    // Strobes, bus drive and hold are registered so the UART pins never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rdn      <= 1'b1;
            wrn      <= 1'b1;
            bus_hold <= 1'b0;
            drive_q  <= 1'b0;
            wbyte_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rdn      <= rdn_d;
            wrn      <= wrn_d;
            bus_hold <= hold_d;
            drive_q  <= drive_d;
            wbyte_q  <= wbyte_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rdn_d       = rdn;
        wrn_d       = wrn;
        hold_d      = bus_hold;
        drive_d     = drive_q;
        wbyte_d     = wbyte_q;
        rdata_d     = rdata_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_en      = 1'b0;
        set_tx_busy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host.req_write) begin
                    if (!host.req_cmd && tx_ready) begin
                        wbyte_d  = host.wdata;
                        drive_d  = 1'b1;
                        hold_d   = 1'b1;
                        wrn_d    = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(WR_PULSE - 1);
                        state_d  = ST_WR_STROBE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (host.req_read) begin
                    if (host.req_cmd) begin
                        rdata_d = status_word(data_ready, tx_ready);
                        state_d = ST_DONE;
                    end else if (data_ready) begin
                        hold_d   = 1'b1;
                        rdn_d    = 1'b0;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(RD_PULSE - 1);
                        state_d  = ST_RD_STROBE;
                    end else begin
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD_STROBE: begin
                tmr_en = 1'b1;
                if (tmr_last) begin
                    rdata_d = {8'h00, bus_data};
                    rdn_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR_STROBE: begin
                tmr_en = 1'b1;
                // Bus stays driven into DONE so data outlives the wrn rise by a cycle.
                if (tmr_last) begin
                    wrn_d       = 1'b1;
                    set_tx_busy = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                hold_d  = 1'b0;
                drive_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_busy <= 1'b0;
        end else if (set_tx_busy) begin
            tx_busy <= 1'b1;
        end else if (tx_busy && tbre && tsre) begin
            tx_busy <= 1'b0;
        end
    end

    assign tx_ready   = tbre & tsre & ~tx_busy;
    assign bus_data   = drive_q ? wbyte_q : 8'hzz;
    assign host.rdata = rdata_q;
    assign host.busy  = (state_q != ST_IDLE);
    assign host.done  = (state_q == ST_DONE);

endmodule
